// File: rtl/add_nibble_seq.sv
// rtl/add_nibble_seq.sv - nibble-serial W-bit adder sequencer driving an external 4-bit adder stage
//
// Purpose:
//   Accepts an operand pair (in_a, in_b, in_cin) and computes A+B+cin one
//   nibble per clock through an external combinational 4-bit adder stage.
//   The result is presented with a valid/ready handshake.
//
// Parameters:
//   NIBBLES  operand width in nibbles (2..8)
//   W        operand width in bits, derived as 4*NIBBLES (do not override)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin  operands and carry in
//   nib_a, nib_b        current operand nibbles to the adder stage (0 outside RUN)
//   nib_cin             carry into the adder stage (0 outside RUN)
//   nib_sum, nib_cout   adder stage results
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_sum, out_carry  result and carry out of the top nibble
//   out_ovf             two's-complement overflow (only with ADD_NIBBLE_SEQ_OVF_EN)
//
// Build option: define ADD_NIBBLE_SEQ_OVF_EN to add the out_ovf port.

module add_nibble_seq #(
    parameter int NIBBLES = 4,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic [3:0]   nib_a,
    output logic [3:0]   nib_b,
    output logic         nib_cin,
    input  logic [3:0]   nib_sum,
    input  logic         nib_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
`ifdef ADD_NIBBLE_SEQ_OVF_EN
    output logic         out_ovf,
`endif
    output logic         out_carry
);

    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    // Operands are shifted down one nibble per RUN edge so the low nibble is
    // always the current one. After the last nibble they have shifted out to
    // zero, which keeps nib_a/nib_b at 0 outside RUN with no extra gating.
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic          carry;
    logic [W-1:0]  result;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
    logic          ovf;
`endif

    assign nib_a   = a_sh[3:0];
    assign nib_b   = b_sh[3:0];
    assign nib_cin = carry;
    assign out_sum = result;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
    assign out_ovf = ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            result    <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh      <= in_a;
                        b_sh      <= in_b;
                        carry     <= in_cin;
                        idx       <= '0;
                        result    <= '0;
                        out_carry <= 1'b0;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
                        ovf       <= 1'b0;
`endif
                        in_ready  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= nib_sum;
                    a_sh <= a_sh >> 4;
                    b_sh <= b_sh >> 4;
                    if (idx == LAST) begin
                        idx       <= '0;
                        carry     <= 1'b0;
                        out_carry <= nib_cout;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
                        // The top nibble is on the adder now, so its bit 3
                        // is the sign of each operand and of the sum.
                        ovf       <= (nib_a[3] == nib_b[3]) && (nib_sum[3] != nib_a[3]);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        carry <= nib_cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_nibble_seq.sv
// tb/tb_add_nibble_seq.sv - self-checking bench for add_nibble_seq

module tb_add_nibble_seq;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [3:0]   nib_a;
    logic [3:0]   nib_b;
    logic         nib_cin;
    logic [3:0]   nib_sum;
    logic         nib_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
    logic         out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External combinational 4-bit adder stage.
    assign {nib_cout, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, nib_cin};

    add_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .nib_a     (nib_a),
        .nib_b     (nib_b),
        .nib_cin   (nib_cin),
        .nib_sum   (nib_sum),
        .nib_cout  (nib_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef ADD_NIBBLE_SEQ_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_carry (out_carry)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    vec_t tbl[6];

    logic [3:0] cin_log;
    logic [W-1:0] got_sum;
    logic got_carry;
    int got_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair and hold it until the edge that accepts it.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("issue_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the accepting edge; returns when out_valid is seen.
    task automatic wait_result(output logic [W-1:0] s, output logic c, output int lat);
        lat = 0;
        cin_log = 4'h0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) cin_log[lat] = nib_cin;
            tick();
            lat++;
        end
        if (lat >= 20) chk("result_timeout", 32'd0, 32'd1);
        s = out_sum;
        c = out_carry;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] r;
        r = ref_add(a, b, cin);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    initial begin
        logic [W-1:0] held;
        logic [W:0] r;
        logic [W-1:0] ra, rb;
        logic rc;
        int dly;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_out_carry", 32'(out_carry), 32'd0);
        chk("reset_nib", 32'({nib_a, nib_b, nib_cin}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors.
        foreach (tbl[i]) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].cin);
            wait_result(got_sum, got_carry, got_lat);
            chk($sformatf("tbl%0d_sum", i), 32'(got_sum), 32'(tbl[i].sum));
            chk($sformatf("tbl%0d_carry", i), 32'(got_carry), 32'(tbl[i].carry));
            chk($sformatf("tbl%0d_latency", i), 32'(got_lat), NIBBLES);
            chk($sformatf("tbl%0d_nib_done", i), 32'({nib_a, nib_b, nib_cin}), 32'd0);
`ifdef ADD_NIBBLE_SEQ_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), 32'(out_ovf), 32'(tbl[i].ovf));
`endif
            if (i == 1) chk("ripple_nib_cin_seq", 32'(cin_log), 32'h0000_000E);
            tick();
            chk($sformatf("tbl%0d_idle_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("tbl%0d_idle_hold", i), 32'(out_sum), 32'(tbl[i].sum));
        end

        // Backpressure: result held with out_ready low, in_valid ignored.
        out_ready = 1'b0;
        issue(16'h1111, 16'h2222, 1'b1);
        wait_result(got_sum, got_carry, got_lat);
        chk("bp_sum", 32'(got_sum), 32'h3334);
        held = got_sum;
        in_a = 16'h0F0F;
        in_b = 16'h0101;
        in_cin = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_stable%0d", k), 32'(out_sum), 32'(held));
            chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_to_idle_valid", 32'(out_valid), 32'd0);
        chk("bp_to_idle_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_hold", 32'(out_sum), 32'(held));
        tick();
        in_valid = 1'b0;
        chk("bp_accept", 32'(in_ready), 32'd0);
        wait_result(got_sum, got_carry, got_lat);
        chk("bp_next_sum", 32'(got_sum), 32'h1010);
        chk("bp_next_latency", 32'(got_lat), NIBBLES);
        tick();

        // Reset abort in RUN at idx=2.
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        tick();
        chk("abort_pre_nib_a", 32'(nib_a), 32'hF);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_nib", 32'({nib_a, nib_b, nib_cin}), 32'd0);
        chk("abort_out_sum", 32'(out_sum), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        chk("abort_idle_valid", 32'(out_valid), 32'd0);
        issue(16'h0ABC, 16'h0123, 1'b0);
        wait_result(got_sum, got_carry, got_lat);
        chk("abort_next_sum", 32'(got_sum), 32'h0BDF);
        tick();

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 2);
            r = ref_add(ra, rb, rc);
            out_ready = (dly == 0);
            issue(ra, rb, rc);
            wait_result(got_sum, got_carry, got_lat);
            chk("rand_sum", 32'(got_sum), 32'(r[W-1:0]));
            chk("rand_carry", 32'(got_carry), 32'(r[W]));
            chk("rand_latency", 32'(got_lat), NIBBLES);
`ifdef ADD_NIBBLE_SEQ_OVF_EN
            chk("rand_ovf", 32'(out_ovf), 32'(ref_ovf(ra, rb, rc)));
`endif
            for (int k = 0; k < dly; k++) begin
                tick();
                chk("rand_hold", 32'({out_valid, out_sum}), 32'({1'b1, r[W-1:0]}));
            end
            out_ready = 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_nibble_seq.md
ADD_NIBBLE_SEQ -- requirements
Module: add_nibble_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (legal 2..8).
REQ-002 SHALL have parameter W, default 4*NIBBLES, giving the operand width in bits; W is derived and SHALL NOT be overridden.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_a  input  W  operand A.
REQ-008 in_b  input  W  operand B.
REQ-009 in_cin  input  1  carry into nibble 0.
REQ-010 nib_a  output  4  current A nibble to the 4-bit adder stage.
REQ-011 nib_b  output  4  current B nibble to the 4-bit adder stage.
REQ-012 nib_cin  output  1  carry into the 4-bit adder stage.
REQ-013 nib_sum  input  4  sum returned by the combinational 4-bit adder stage.
REQ-014 nib_cout  input  1  carry-out returned by the 4-bit adder stage.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_sum  output  W  result A+B+cin modulo 2^W.
REQ-018 out_carry  output  1  carry out of the top nibble.

Function
REQ-019 SHALL implement FSM states IDLE, RUN and DONE.
REQ-020 In IDLE, in_ready SHALL be 1; in_ready SHALL be 0 in every other state.
REQ-021 On a clock edge with IDLE and in_valid=1: latch in_a, in_b and in_cin; clear nibble index idx to 0; load the carry register with in_cin; clear the result register; go to RUN.
REQ-022 In RUN, nib_a/nib_b SHALL be nibble idx of the latched operands and nib_cin SHALL be the carry register, all driven from registers with no combinational path from inputs.
REQ-023 Each RUN edge SHALL write nib_sum into result nibble idx, load nib_cout into the carry register, and increment idx.
REQ-024 On the RUN edge with idx=NIBBLES-1: write the last nibble, load out_carry from nib_cout, and go to DONE.
REQ-025 out_valid SHALL be 1 exactly in DONE; out_valid rises NIBBLES cycles after the accepting edge.
REQ-026 DONE with out_ready=1 SHALL return to IDLE on the next edge; with out_ready=0 it SHALL hold, with out_sum/out_carry stable.
REQ-027 in_valid SHALL be ignored outside IDLE, and new operands SHALL NOT be accepted in the DONE->IDLE cycle.
REQ-028 Minimum issue interval SHALL be NIBBLES+2 cycles.
REQ-029 Outside RUN, nib_a, nib_b and nib_cin SHALL be 0.
REQ-030 out_sum and out_carry SHALL hold the last result in IDLE until the next accept clears them.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, idx=0, carry=0, result=0, out_carry=0, out_valid=0, nib_*=0 and in_ready=1 after release.
REQ-032 Reset asserted in RUN or DONE SHALL abort the operation with no result issued.

Configuration
REQ-033 With macro ADD_NIBBLE_SEQ_OVF_EN defined, the block SHALL add output out_ovf (1 bit), registered in DONE.
REQ-034 out_ovf SHALL equal (A[W-1]==B[W-1]) && (out_sum[W-1]!=A[W-1]), which is two's-complement overflow.
REQ-035 out_ovf SHALL reset to 0 and clear on accept.
REQ-036 Without ADD_NIBBLE_SEQ_OVF_EN, the port SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-037 NIBBLES=4, in_a=0x1234, in_b=0x4321, in_cin=0, out_ready=1 -> out_valid 4 cycles after accept, out_sum=0x5555, out_carry=0.
REQ-038 in_a=0xFFFF, in_b=0x0001, in_cin=0 -> carry ripples through all nibbles: nib_cin sequence 0,1,1,1, out_sum=0x0000, out_carry=1.
REQ-039 in_a=0x0000, in_b=0x0000, in_cin=1 -> out_sum=0x0001, out_carry=0.
REQ-040 Result valid with out_ready held 0 for 3 cycles, in_valid=1 throughout -> out_valid and out_sum stable, in_ready=0, next operand accepted only in IDLE.
REQ-041 rst_n pulsed low during RUN at idx=2 -> outputs immediately reset, out_valid never asserts for the aborted operation, next operation correct.
REQ-042 ADD_NIBBLE_SEQ_OVF_EN defined, in_a=0x7FFF, in_b=0x0001 -> out_sum=0x8000, out_ovf=1; in_a=0xFFFF, in_b=0x0001 -> out_ovf=0.
